// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler
//   Single-request DRAM command sequencer with a per-bank open-row table.
//   An accepted request is classified as hit / closed / conflict and turned
//   into the matching PRE -> ACT -> RD/WR sequence, honouring T_RP and T_RCD.
//   Refresh has priority at IDLE and is sequenced as PREA (if needed) -> REF,
//   followed by a refresh_ack pulse T_RFC cycles after REF.
//
// Ports
//   clk, rst_b                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE, no refresh)
//   req_we/req_bank/row/col     request attributes, latched on acceptance
//   refresh_req/refresh_ack     level refresh request / one-cycle completion pulse
//   cmd_valid/cmd               registered command strobe and opcode
//   cmd_bank/cmd_row/cmd_col    registered command address (unused fields zero)
//   busy                        high whenever the FSM is outside IDLE
module dram_cmd_scheduler #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RP         = 2,
    parameter int T_RCD        = 2,
    parameter int T_RFC        = 8
) (
    input  logic                            clk,
    input  logic                            rst_b,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] req_bank,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]  req_row,
    input  logic [$clog2(NUM_OF_COLS)-1:0]  req_col,
    input  logic                            refresh_req,
    output logic                            refresh_ack,
    output logic                            cmd_valid,
    output logic [2:0]                      cmd,
    output logic [$clog2(NUM_OF_BANKS)-1:0] cmd_bank,
    output logic [$clog2(NUM_OF_ROWS)-1:0]  cmd_row,
    output logic [$clog2(NUM_OF_COLS)-1:0]  cmd_col,
    output logic                            busy
);

    localparam int BANK_W = $clog2(NUM_OF_BANKS);
    localparam int ROW_W  = $clog2(NUM_OF_ROWS);
    localparam int COL_W  = $clog2(NUM_OF_COLS);
    localparam int T_MAX0 = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int T_MAX  = (T_MAX0 > T_RFC) ? T_MAX0 : T_RFC;
    localparam int CNT_W  = $clog2(T_MAX + 1);

    // Counters hold "cycles remaining minus one": the state that loads them
    // is already the first wait cycle, so the next command issues on zero.
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'(T_RFC - 1);

    localparam logic [2:0] CMD_NOP  = 3'b000;
    localparam logic [2:0] CMD_ACT  = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;
    localparam logic [2:0] CMD_WR   = 3'b011;
    localparam logic [2:0] CMD_PRE  = 3'b100;
    localparam logic [2:0] CMD_PREA = 3'b101;
    localparam logic [2:0] CMD_REF  = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_ACT, S_ACCESS, S_REF_PRE, S_REF
    } state_t;

    state_t                                state_q, state_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic                                  we_q, we_d;
    logic [BANK_W-1:0]                     bank_q, bank_d;
    logic [ROW_W-1:0]                      row_q, row_d;
    logic [COL_W-1:0]                      col_q, col_d;
    logic [NUM_OF_BANKS-1:0]               open_vld_q, open_vld_d;
    logic [NUM_OF_BANKS-1:0][ROW_W-1:0]    open_row_q, open_row_d;
    logic [2:0]                            cmd_q, cmd_d;
    logic [BANK_W-1:0]                     cmd_bank_q, cmd_bank_d;
    logic [ROW_W-1:0]                      cmd_row_q, cmd_row_d;
    logic [COL_W-1:0]                      cmd_col_q, cmd_col_d;
    logic                                  ack_q, ack_d;

    function automatic logic [2:0] access_cmd(input logic we);
        return we ? CMD_WR : CMD_RD;
    endfunction

    assign busy        = (state_q != S_IDLE);
    // Gated by rst_b so ready stays low while reset is held.
    assign req_ready   = rst_b && (state_q == S_IDLE) && !refresh_req;
    assign cmd         = cmd_q;
    assign cmd_valid   = (cmd_q != CMD_NOP);
    assign cmd_bank    = cmd_bank_q;
    assign cmd_row     = cmd_row_q;
    assign cmd_col     = cmd_col_q;
    assign refresh_ack = ack_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        bank_d     = bank_q;
        row_d      = row_q;
        col_d      = col_q;
        open_vld_d = open_vld_q;
        open_row_d = open_row_q;
        cmd_d      = CMD_NOP;
        cmd_bank_d = '0;
        cmd_row_d  = '0;
        cmd_col_d  = '0;
        ack_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (refresh_req) begin
                    if (|open_vld_q) begin
                        cmd_d      = CMD_PREA;
                        open_vld_d = '0;
                        cnt_d      = RP_LOAD;
                        state_d    = S_REF_PRE;
                    end else begin
                        cmd_d   = CMD_REF;
                        cnt_d   = RFC_LOAD;
                        state_d = S_REF;
                    end
                end else if (req_valid && req_ready) begin
                    we_d   = req_we;
                    bank_d = req_bank;
                    row_d  = req_row;
                    col_d  = req_col;
                    // The first command of the sequence is issued from the
                    // live request so it appears in the cycle after acceptance.
                    if (open_vld_q[req_bank] && (open_row_q[req_bank] == req_row)) begin
                        cmd_d      = access_cmd(req_we);
                        cmd_bank_d = req_bank;
                        cmd_col_d  = req_col;
                        state_d    = S_ACCESS;
                    end else if (open_vld_q[req_bank]) begin
                        cmd_d                = CMD_PRE;
                        cmd_bank_d           = req_bank;
                        open_vld_d[req_bank] = 1'b0;
                        cnt_d                = RP_LOAD;
                        state_d              = S_PRE;
                    end else begin
                        cmd_d                = CMD_ACT;
                        cmd_bank_d           = req_bank;
                        cmd_row_d            = req_row;
                        open_vld_d[req_bank] = 1'b1;
                        open_row_d[req_bank] = req_row;
                        cnt_d                = RCD_LOAD;
                        state_d              = S_ACT;
                    end
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    cmd_d              = CMD_ACT;
                    cmd_bank_d         = bank_q;
                    cmd_row_d          = row_q;
                    open_vld_d[bank_q] = 1'b1;
                    open_row_d[bank_q] = row_q;
                    cnt_d              = RCD_LOAD;
                    state_d            = S_ACT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACT: begin
                if (cnt_q == '0) begin
                    cmd_d      = access_cmd(we_q);
                    cmd_bank_d = bank_q;
                    cmd_col_d  = col_q;
                    state_d    = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // RD/WR is on the bus this cycle; IDLE follows.
            S_ACCESS: state_d = S_IDLE;
            S_REF_PRE: begin
                if (cnt_q == '0) begin
                    cmd_d   = CMD_REF;
                    cnt_d   = RFC_LOAD;
                    state_d = S_REF;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_REF: begin
                if (cnt_q == '0) begin
                    ack_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            bank_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            open_vld_q <= '0;
            open_row_q <= '0;
            cmd_q      <= CMD_NOP;
            cmd_bank_q <= '0;
            cmd_row_q  <= '0;
            cmd_col_q  <= '0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            bank_q     <= bank_d;
            row_q      <= row_d;
            col_q      <= col_d;
            open_vld_q <= open_vld_d;
            open_row_q <= open_row_d;
            cmd_q      <= cmd_d;
            cmd_bank_q <= cmd_bank_d;
            cmd_row_q  <= cmd_row_d;
            cmd_col_q  <= cmd_col_d;
            ack_q      <= ack_d;
        end
    end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed testbench for dram_cmd_scheduler (default parameters).
// Observed command bundle: {cmd_valid, cmd, cmd_bank, cmd_row, cmd_col}.
module tb_dram_cmd_scheduler;

    typedef logic [16:0] obs_t;

    localparam logic [2:0] C_ACT  = 3'b001;
    localparam logic [2:0] C_RD   = 3'b010;
    localparam logic [2:0] C_WR   = 3'b011;
    localparam logic [2:0] C_PRE  = 3'b100;
    localparam logic [2:0] C_PREA = 3'b101;
    localparam logic [2:0] C_REF  = 3'b110;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       req_valid, req_ready, req_we;
    logic [2:0] req_bank;
    logic [6:0] req_row;
    logic [2:0] req_col;
    logic       refresh_req, refresh_ack;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [2:0] cmd_bank;
    logic [6:0] cmd_row;
    logic [2:0] cmd_col;
    logic       busy;
    obs_t       obs;

    int n_chk  = 0;
    int n_pass = 0;

    dram_cmd_scheduler dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_bank    (req_bank),
        .req_row     (req_row),
        .req_col     (req_col),
        .refresh_req (refresh_req),
        .refresh_ack (refresh_ack),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_bank    (cmd_bank),
        .cmd_row     (cmd_row),
        .cmd_col     (cmd_col),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    assign obs = {cmd_valid, cmd, cmd_bank, cmd_row, cmd_col};

    function automatic obs_t mk(input logic [2:0] c, input int b, input int r, input int col);
        logic [2:0] bb;
        logic [6:0] rr;
        logic [2:0] cc;
        bb = b[2:0];
        rr = r[6:0];
        cc = col[2:0];
        return {(c != 3'b000), c, bb, rr, cc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input int b, input int r, input int c);
        req_valid = 1'b1;
        req_we    = we;
        req_bank  = b[2:0];
        req_row   = r[6:0];
        req_col   = c[2:0];
    endtask

    task automatic test_reset();
        step();
        step();
        n_chk++;
        if (obs !== '0 || busy !== 1'b0 || req_ready !== 1'b0 || refresh_ack !== 1'b0)
            $display("FAIL reset_outputs: got obs=%h busy=%b ready=%b ack=%b want all zero",
                     obs, busy, req_ready, refresh_ack);
        else n_pass++;
        rst_b = 1'b1;
        #1;
        n_chk++;
        if (req_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_release_ready: got ready=%b busy=%b want 1/0", req_ready, busy);
        else n_pass++;
    endtask

    task automatic test_refresh_closed();
        int acks;
        obs_t e;
        acks = 0;
        refresh_req = 1'b1;
        #1;
        n_chk++;
        if (req_ready !== 1'b0)
            $display("FAIL ref_closed_ready_R: got %b want 0", req_ready);
        else n_pass++;
        step();
        refresh_req = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            e = (i == 1) ? mk(C_REF, 0, 0, 0) : '0;
            n_chk++;
            if (obs !== e || refresh_ack !== (i == 9) || req_ready !== (i >= 9))
                $display("FAIL ref_closed R+%0d: got obs=%h ack=%b ready=%b want obs=%h ack=%b ready=%b",
                         i, obs, refresh_ack, req_ready, e, (i == 9), (i >= 9));
            else n_pass++;
            if (refresh_ack === 1'b1) acks++;
            if (i < 12) step();
        end
        n_chk++;
        if (acks != 1) $display("FAIL ref_closed_ack_count: got %0d want 1", acks);
        else n_pass++;
    endtask

    task automatic test_closed_read();
        obs_t exp [4];
        exp[0] = mk(C_ACT, 3, 5, 0);
        exp[1] = '0;
        exp[2] = mk(C_RD, 3, 0, 2);
        exp[3] = '0;
        n_chk++;
        if (req_ready !== 1'b1) $display("FAIL closed_rd_ready_A: got %b want 1", req_ready);
        else n_pass++;
        set_req(1'b0, 3, 5, 2);
        step();
        req_valid = 1'b0;
        n_chk++;
        if (busy !== 1'b1) $display("FAIL closed_rd_busy: got %b want 1", busy);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (obs !== exp[i])
                $display("FAIL closed_rd A+%0d: got %h want %h", i + 1, obs, exp[i]);
            else n_pass++;
            if (i < 3) step();
        end
        n_chk++;
        if (req_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL closed_rd_idle_A+4: got ready=%b busy=%b want 1/0", req_ready, busy);
        else n_pass++;
    endtask

    task automatic test_hit_write();
        set_req(1'b1, 3, 5, 7);
        step();
        req_valid = 1'b0;
        n_chk++;
        if (obs !== mk(C_WR, 3, 0, 7))
            $display("FAIL hit_wr A+1: got %h want %h", obs, mk(C_WR, 3, 0, 7));
        else n_pass++;
        step();
        n_chk++;
        if (obs !== '0 || req_ready !== 1'b1)
            $display("FAIL hit_wr A+2: got obs=%h ready=%b want 0/1", obs, req_ready);
        else n_pass++;
    endtask

    task automatic test_conflict_read();
        obs_t exp [6];
        exp[0] = mk(C_PRE, 3, 0, 0);
        exp[1] = '0;
        exp[2] = mk(C_ACT, 3, 9, 0);
        exp[3] = '0;
        exp[4] = mk(C_RD, 3, 0, 0);
        exp[5] = '0;
        set_req(1'b0, 3, 9, 0);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (obs !== exp[i])
                $display("FAIL conflict_rd A+%0d: got %h want %h", i + 1, obs, exp[i]);
            else n_pass++;
            if (i < 5) step();
        end
        n_chk++;
        if (req_ready !== 1'b1) $display("FAIL conflict_rd_ready: got %b want 1", req_ready);
        else n_pass++;
        // Row 9 must now be open in bank 3: a read there is a direct hit.
        set_req(1'b0, 3, 9, 1);
        step();
        req_valid = 1'b0;
        n_chk++;
        if (obs !== mk(C_RD, 3, 0, 1))
            $display("FAIL row9_hit A+1: got %h want %h", obs, mk(C_RD, 3, 0, 1));
        else n_pass++;
        step();
    endtask

    task automatic test_refresh_open();
        obs_t e;
        obs_t exp [3];
        refresh_req = 1'b1;
        set_req(1'b0, 3, 9, 4);
        #1;
        n_chk++;
        if (req_ready !== 1'b0) $display("FAIL ref_open_ready_R: got %b want 0", req_ready);
        else n_pass++;
        step();
        refresh_req = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            e = (i == 1) ? mk(C_PREA, 0, 0, 0) : (i == 3) ? mk(C_REF, 0, 0, 0) : '0;
            n_chk++;
            if (obs !== e || refresh_ack !== (i == 11) || req_ready !== (i == 11))
                $display("FAIL ref_open R+%0d: got obs=%h ack=%b ready=%b want obs=%h ack=%b ready=%b",
                         i, obs, refresh_ack, req_ready, e, (i == 11), (i == 11));
            else n_pass++;
            if (i < 11) step();
        end
        // Request held since R is accepted at R+11; PREA closed the bank.
        step();
        req_valid = 1'b0;
        exp[0] = mk(C_ACT, 3, 9, 0);
        exp[1] = '0;
        exp[2] = mk(C_RD, 3, 0, 4);
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs !== exp[i] || refresh_ack !== 1'b0)
                $display("FAIL ref_open_post A+%0d: got obs=%h ack=%b want obs=%h ack=0",
                         i + 1, obs, refresh_ack, exp[i]);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_reset_mid();
        obs_t exp [4];
        set_req(1'b0, 5, 2, 3);
        step();
        req_valid = 1'b0;
        n_chk++;
        if (obs !== mk(C_ACT, 5, 2, 0))
            $display("FAIL mid_rst_act: got %h want %h", obs, mk(C_ACT, 5, 2, 0));
        else n_pass++;
        rst_b = 1'b0;
        #1;
        n_chk++;
        if (obs !== '0 || busy !== 1'b0 || req_ready !== 1'b0 || refresh_ack !== 1'b0)
            $display("FAIL mid_rst_outputs: got obs=%h busy=%b ready=%b ack=%b want all zero",
                     obs, busy, req_ready, refresh_ack);
        else n_pass++;
        step();
        rst_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++;
            if (obs !== '0 || busy !== 1'b0)
                $display("FAIL mid_rst_quiet cyc%0d: got obs=%h busy=%b want 0/0", i, obs, busy);
            else n_pass++;
        end
        exp[0] = mk(C_ACT, 5, 2, 0);
        exp[1] = '0;
        exp[2] = mk(C_RD, 5, 0, 3);
        exp[3] = '0;
        set_req(1'b0, 5, 2, 3);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (obs !== exp[i])
                $display("FAIL mid_rst_retry A+%0d: got %h want %h", i + 1, obs, exp[i]);
            else n_pass++;
            if (i < 3) step();
        end
    endtask

    initial begin
        rst_b       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_bank    = '0;
        req_row     = '0;
        req_col     = '0;
        refresh_req = 1'b0;
        test_reset();
        test_refresh_closed();
        test_closed_read();
        test_hit_write();
        test_conflict_read();
        test_refresh_open();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
